// File: rtl/ram.sv
// 256 x 16 single-port register-array memory: synchronous write and
// whole-array synchronous clear, combinational read.
module ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= din;
    end
  end

  // A same-address write appears on dout right after the edge via this path.
  assign dout = mem_q[addr];

endmodule

// File: tb/tb_ram.sv
// Directed, table-driven check of the ram block: clear sweep, writes,
// holds, overwrite, reset priority and combinational read.
module tb_ram;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [7:0]  addr;
  logic        we;
  logic [15:0] dout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] din;
    bit          edge_en;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .addr (addr),
    .we   (we),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [7:0] a,
                              input logic [15:0] d, input bit e, input logic [15:0] x,
                              input string n);
    vec_t v;
    v.rst_n = r; v.we = w; v.addr = a; v.din = d; v.edge_en = e; v.exp = x; v.name = n;
    return v;
  endfunction

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs.push_back(mk(1, 1, 8'h00, 16'hA00A, 1, 16'hA00A, "wr00"));
    vecs.push_back(mk(1, 0, 8'h00, 16'h400A, 1, 16'hA00A, "hold00_din_ignored"));
    vecs.push_back(mk(1, 0, 8'h01, 16'h9C04, 1, 16'h0000, "hold01"));
    vecs.push_back(mk(1, 1, 8'h01, 16'h9C04, 1, 16'h9C04, "wr01"));
    vecs.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 16'hA00A, "neighbour00"));
    vecs.push_back(mk(1, 1, 8'h00, 16'hE00A, 1, 16'hE00A, "overwr00"));
    vecs.push_back(mk(1, 1, 8'h01, 16'h8000, 1, 16'h8000, "overwr01"));
    vecs.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 16'hE00A, "reread00"));
    vecs.push_back(mk(0, 1, 8'h05, 16'hFFFF, 1, 16'h0000, "rst_vs_wr05"));
    vecs.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 16'h0000, "post_rst00"));
    vecs.push_back(mk(1, 0, 8'h01, 16'h0000, 0, 16'h0000, "post_rst01"));
    vecs.push_back(mk(1, 0, 8'h05, 16'h0000, 0, 16'h0000, "post_rst05"));
    vecs.push_back(mk(1, 1, 8'hFF, 16'hFFFF, 1, 16'hFFFF, "wrFF"));
    vecs.push_back(mk(1, 1, 8'h80, 16'h5A5A, 1, 16'h5A5A, "wr80"));
    vecs.push_back(mk(1, 0, 8'hFF, 16'h0000, 0, 16'hFFFF, "combFF"));
    vecs.push_back(mk(1, 0, 8'h80, 16'h0000, 0, 16'h5A5A, "comb80"));
    vecs.push_back(mk(1, 0, 8'hFF, 16'h0000, 0, 16'hFFFF, "combFF_again"));
    vecs.push_back(mk(1, 0, 8'h7F, 16'h0000, 0, 16'h0000, "untouched7F"));

    // Reset, then sweep every address with no clock edge.
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 8'h00;
    din   = 16'h1234;
    step_edge();
    rst_n = 1'b1;
    for (int a = 0; a < 256; a++) begin
      addr = a[7:0];
      #1;
      check($sformatf("clear_sweep_%02h", a), dout, 16'h0000);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      we    = vecs[i].we;
      addr  = vecs[i].addr;
      din   = vecs[i].din;
      if (vecs[i].edge_en) step_edge();
      else #1;
      check(vecs[i].name, dout, vecs[i].exp);
    end

    // Read-during-write, same address: old word before the edge, new right after.
    rst_n = 1'b1;
    we    = 1'b1;
    addr  = 8'h10;
    din   = 16'h1111;
    step_edge();
    din   = 16'h2222;
    #1;
    check("rdw_before_edge", dout, 16'h1111);
    step_edge();
    check("rdw_after_edge", dout, 16'h2222);

    // Back-to-back writes to one address: the last one wins.
    addr = 8'h20;
    din  = 16'h3333;
    step_edge();
    din  = 16'h4444;
    step_edge();
    we   = 1'b0;
    din  = 16'hDEAD;
    step_edge();
    check("b2b_last_wins", dout, 16'h4444);

    // Earlier contents survive the unrelated writes.
    addr = 8'h10;
    #1;
    check("rdw_word_kept", dout, 16'h2222);
    addr = 8'h80;
    #1;
    check("w80_kept", dout, 16'h5A5A);

    // Second reset clears everything written since the first.
    rst_n = 1'b0;
    step_edge();
    rst_n = 1'b1;
    for (int a = 0; a < 256; a++) begin
      addr = a[7:0];
      #1;
      check($sformatf("clear2_sweep_%02h", a), dout, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
